// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronizes the raw lines, deframes and validates 11-bit frames,
// and buffers scan codes in a small FIFO drained by a nextdata_n handshake.
// Optional build macro: PS2_PARITY_CHECK_EN rejects frames with incorrect odd parity.
module ps2_rx_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int TIMEOUT    = 5000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

  typedef enum logic {IDLE, RECV} state_t;

  logic [2:0]             pc_sync_q, pc_sync_d;
  logic [1:0]             pd_sync_q, pd_sync_d;
  state_t                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic                   frame_err_q, frame_err_d;
  logic                   nd_q, nd_d, nd_dly_q, nd_dly_d;
  logic                   ovf_q, ovf_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][7:0]  mem_q, mem_d;

  logic fall, bit_in, frame_ok, wr_en;
  logic empty, full, pop, push, drop;

  assign fall   = (pc_sync_q[2:1] == 2'b10);
  assign bit_in = pd_sync_q[1];

  // bit_in is the stop bit when this is consulted; shreg/par hold the rest of the frame
`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = bit_in & (^{shreg_q, par_q});
`else
  assign frame_ok = bit_in;
`endif

  always_comb begin
    pc_sync_d   = {pc_sync_q[1:0], ps2_clk};
    pd_sync_d   = {pd_sync_q[0], ps2_data};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    to_cnt_d    = to_cnt_q;
    frame_err_d = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (fall) begin
          if (!bit_in) begin
            state_d   = RECV;
            bit_cnt_d = 4'd1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (fall) begin
          to_cnt_d  = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q <= 4'd8) begin
            shreg_d = {bit_in, shreg_q[7:1]};
          end else if (bit_cnt_q == 4'd9) begin
            par_d = bit_in;
          end else begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            if (frame_ok) wr_en = 1'b1;
            else          frame_err_d = 1'b1;
          end
        end else if (to_cnt_q == TO_MAX) begin
          // device stalled mid-frame: drop the partial byte
          state_d     = IDLE;
          bit_cnt_d   = '0;
          shreg_d     = '0;
          to_cnt_d    = '0;
          frame_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    nd_d     = nextdata_n;
    nd_dly_d = nd_q;
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
               (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    pop      = nd_dly_q & ~nd_q & ~empty;
    // a same-cycle pop frees the slot the write lands in
    push     = wr_en & (~full | pop);
    drop     = wr_en & full & ~pop;
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = shreg_q;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    ovf_d    = ovf_q;
    if (drop)     ovf_d = 1'b1;
    else if (pop) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_sync_q   <= 3'b111;
      pd_sync_q   <= 2'b11;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      frame_err_q <= 1'b0;
      nd_q        <= 1'b1;
      nd_dly_q    <= 1'b1;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_q       <= '0;
    end else begin
      pc_sync_q   <= pc_sync_d;
      pd_sync_q   <= pd_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      frame_err_q <= frame_err_d;
      nd_q        <= nd_d;
      nd_dly_q    <= nd_dly_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
    end
  end

  assign data      = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign ready     = ~empty;
  assign overflow  = ovf_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames are bit-banged on the PS/2 lines, outputs checked
// against hand-computed values with immediate assertions.
module tb_ps2_rx_fifo;
  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready, overflow, frame_err;

  int n_asserts = 0;
  int n_fail    = 0;
  int err_cnt   = 0;
  int err_base;

  ps2_rx_fifo #(.DEPTH_LOG2(3), .TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err) err_cnt <= err_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // nbits < 11 truncates the frame; pop_at_stop drops nextdata_n so the pop lands on the write edge
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits,
                            input logic pop_at_stop);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      cyc(10);
      ps2_clk = 1'b0;
      if (i == 10 && pop_at_stop) begin
        cyc(1);
        nextdata_n = 1'b0;
        cyc(19);
      end else begin
        cyc(20);
      end
      ps2_clk = 1'b1;
      cyc(10);
    end
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;
    cyc(5);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp, input int hold);
    chk({tag, "_rdy"}, 32'(ready), 32'd1);
    chk({tag, "_data"}, 32'(data), 32'(exp));
    nextdata_n = 1'b0;
    cyc(hold);
    nextdata_n = 1'b1;
    cyc(3);
  endtask

  initial begin
    cyc(3);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    clr = 1'b0;
    cyc(3);

    // single frame, long read pulse pops exactly once
    err_base = err_cnt;
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    send_frame(8'h2D, 1'b0, 11, 1'b0);
    chk("one_ferr", 32'(err_cnt - err_base), 32'd0);
    pop_chk("one_a", 8'h1C, 50);
    pop_chk("one_b", 8'h2D, 50);
    chk("one_empty", 32'(ready), 32'd0);

    // fill past capacity
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b0, 11, 1'b0);
      if (i == 8) chk("ovf_at8", 32'(overflow), 32'd0);
    end
    chk("ovf_at9", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      pop_chk("ovf_pop", 8'(i), 4);
      if (i == 1) chk("ovf_clr", 32'(overflow), 32'd0);
    end
    chk("ovf_empty", 32'(ready), 32'd0);

    // bad parity
    err_base = err_cnt;
    send_frame(8'h1C, 1'b1, 11, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    chk("par_ferr", 32'(err_cnt - err_base), 32'd1);
    chk("par_rdy", 32'(ready), 32'd0);
`else
    chk("par_ferr", 32'(err_cnt - err_base), 32'd0);
    pop_chk("par_pop", 8'h1C, 4);
`endif

    // truncated frame then timeout
    err_base = err_cnt;
    send_frame(8'h55, 1'b0, 5, 1'b0);
    cyc(TO + 10);
    chk("to_ferr", 32'(err_cnt - err_base), 32'd1);
    chk("to_rdy", 32'(ready), 32'd0);
    send_frame(8'hF0, 1'b0, 11, 1'b0);
    chk("to_ferr2", 32'(err_cnt - err_base), 32'd1);
    pop_chk("to_pop", 8'hF0, 4);

    // full FIFO, pop coincides with 9th write
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 11, 1'b0);
    chk("full_ovf0", 32'(overflow), 32'd0);
    send_frame(8'hAA, 1'b0, 11, 1'b1);
    chk("sim_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 7; i++) pop_chk("sim_pop", 8'h12 + 8'(i), 4);
    pop_chk("sim_last", 8'hAA, 4);
    chk("sim_empty", 32'(ready), 32'd0);

    // clr mid-frame
    send_frame(8'h77, 1'b0, 11, 1'b0);
    send_frame(8'h33, 1'b0, 6, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("clr_data", 32'(data), 32'h00);
    chk("clr_rdy", 32'(ready), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_ferr", 32'(frame_err), 32'd0);
    cyc(2);
    clr = 1'b0;
    cyc(3);
    err_base = err_cnt;
    send_frame(8'h5A, 1'b0, 11, 1'b0);
    chk("clr_ferr2", 32'(err_cnt - err_base), 32'd0);
    pop_chk("clr_pop", 8'h5A, 4);
    chk("clr_empty", 32'(ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
